// File: rtl/xy_div_host.sv
// xy_div_host: drives a memory-mapped divide peripheral (write X, write Y,
// wait SETTLE cycles, read quotient) and reports the quotient with a DONE pulse.
module xy_div_host #(
  parameter int unsigned SETTLE = 1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic [15:0] X,
  input  logic [15:0] Y,
  output logic [15:0] RESULT,
  output logic        DONE,
  output logic        BUSY,
  output logic        DZ,
  output logic        ERR,
  output logic [15:0] BUS_D,
  output logic [1:0]  BUS_ADDR,
  output logic        BUS_W,
  output logic        BUS_R,
  output logic        BUS_E,
  input  logic [31:0] BUS_OUT
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR_X,
    S_WR_Y,
    S_SETTLE,
    S_RD_Q,
    S_CAP
  } state_t;

  localparam logic [3:0] SETTLE_M1 = 4'(SETTLE - 1);

  state_t      state_q, state_d;
  logic [15:0] y_q, y_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        arm_q, arm_d;
  logic [15:0] result_q, result_d;
  logic        done_q, done_d;
  logic        busy_q, busy_d;
  logic        dz_q, dz_d;
  logic        err_q, err_d;
  logic [15:0] bus_d_q, bus_d_d;
  logic [1:0]  bus_addr_q, bus_addr_d;
  logic        bus_w_q, bus_w_d;
  logic        bus_r_q, bus_r_d;
  logic        bus_e_q, bus_e_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= S_IDLE;
      y_q        <= '0;
      cnt_q      <= '0;
      arm_q      <= 1'b0;
      result_q   <= '0;
      done_q     <= 1'b0;
      busy_q     <= 1'b0;
      dz_q       <= 1'b0;
      err_q      <= 1'b0;
      bus_d_q    <= '0;
      bus_addr_q <= '0;
      bus_w_q    <= 1'b0;
      bus_r_q    <= 1'b0;
      bus_e_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      y_q        <= y_d;
      cnt_q      <= cnt_d;
      arm_q      <= arm_d;
      result_q   <= result_d;
      done_q     <= done_d;
      busy_q     <= busy_d;
      dz_q       <= dz_d;
      err_q      <= err_d;
      bus_d_q    <= bus_d_d;
      bus_addr_q <= bus_addr_d;
      bus_w_q    <= bus_w_d;
      bus_r_q    <= bus_r_d;
      bus_e_q    <= bus_e_d;
    end
  end

  // Outputs are registered, so each state's bus values are loaded on the
  // edge that enters that state.
  always_comb begin
    state_d    = state_q;
    y_d        = y_q;
    cnt_d      = cnt_q;
    arm_d      = 1'b1;
    result_d   = result_q;
    done_d     = 1'b0;
    busy_d     = busy_q;
    dz_d       = dz_q;
    err_d      = err_q;
    bus_d_d    = bus_d_q;
    bus_addr_d = bus_addr_q;
    bus_w_d    = 1'b0;
    bus_r_d    = 1'b0;
    bus_e_d    = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // arm_q keeps the first edge after reset release from accepting START.
        if (START && arm_q) begin
          y_d   = Y;
          dz_d  = 1'b0;
          err_d = 1'b0;
          if (Y == '0) begin
            dz_d     = 1'b1;
            done_d   = 1'b1;
            result_d = '1;
          end else begin
            busy_d     = 1'b1;
            state_d    = S_WR_X;
            bus_w_d    = 1'b1;
            bus_e_d    = 1'b1;
            bus_addr_d = 2'd0;
            bus_d_d    = X;
          end
        end
      end
      S_WR_X: begin
        state_d    = S_WR_Y;
        bus_w_d    = 1'b1;
        bus_e_d    = 1'b1;
        bus_addr_d = 2'd1;
        bus_d_d    = y_q;
      end
      S_WR_Y: begin
        state_d = S_SETTLE;
        cnt_d   = SETTLE_M1;
      end
      S_SETTLE: begin
        if (cnt_q == '0) begin
          state_d    = S_RD_Q;
          bus_r_d    = 1'b1;
          bus_e_d    = 1'b1;
          bus_addr_d = 2'd2;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RD_Q: begin
        state_d = S_CAP;
      end
      S_CAP: begin
        result_d = BUS_OUT[15:0];
        err_d    = |BUS_OUT[31:16];
        done_d   = 1'b1;
        busy_d   = 1'b0;
        state_d  = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign RESULT   = result_q;
  assign DONE     = done_q;
  assign BUSY     = busy_q;
  assign DZ       = dz_q;
  assign ERR      = err_q;
  assign BUS_D    = bus_d_q;
  assign BUS_ADDR = bus_addr_q;
  assign BUS_W    = bus_w_q;
  assign BUS_R    = bus_r_q;
  assign BUS_E    = bus_e_q;

endmodule

// File: tb/tb_xy_div_host.sv
// Bench for xy_div_host: two instances (SETTLE=1 and SETTLE=4), each with a
// behavioural divide peripheral, checked against arithmetic expectations.
module tb_xy_div_host;

  logic        clk = 1'b0;
  logic        rst;
  logic        start    [2];
  logic [15:0] xin      [2];
  logic [15:0] yin      [2];
  logic [15:0] result   [2];
  logic        done     [2];
  logic        busy     [2];
  logic        dz       [2];
  logic        err      [2];
  logic [15:0] bus_d    [2];
  logic [1:0]  bus_addr [2];
  logic        bus_w    [2];
  logic        bus_r    [2];
  logic        bus_e    [2];
  logic [31:0] bus_out  [2];
  logic [15:0] px       [2];
  logic [15:0] py       [2];
  logic [15:0] last_res [2];

  logic        stub_en;
  logic [31:0] stub_val;
  int          total = 0;
  int          bad = 0;
  int          overlap = 0;
  int          ecnt [2];
  int          dcnt [2];
  logic [18:0] log_q [$];

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        stub;
    logic [15:0] res;
    logic        dz;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vt [8];

  always #5 clk = ~clk;

  xy_div_host #(.SETTLE(1)) u0 (
    .CLK(clk), .RST(rst), .START(start[0]), .X(xin[0]), .Y(yin[0]),
    .RESULT(result[0]), .DONE(done[0]), .BUSY(busy[0]), .DZ(dz[0]), .ERR(err[0]),
    .BUS_D(bus_d[0]), .BUS_ADDR(bus_addr[0]), .BUS_W(bus_w[0]), .BUS_R(bus_r[0]),
    .BUS_E(bus_e[0]), .BUS_OUT(bus_out[0])
  );

  xy_div_host #(.SETTLE(4)) u1 (
    .CLK(clk), .RST(rst), .START(start[1]), .X(xin[1]), .Y(yin[1]),
    .RESULT(result[1]), .DONE(done[1]), .BUSY(busy[1]), .DZ(dz[1]), .ERR(err[1]),
    .BUS_D(bus_d[1]), .BUS_ADDR(bus_addr[1]), .BUS_W(bus_w[1]), .BUS_R(bus_r[1]),
    .BUS_E(bus_e[1]), .BUS_OUT(bus_out[1])
  );

  // Divide peripheral: registers operands on writes, quotient on the read edge.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bus_e[i] && bus_w[i]) begin
        if (bus_addr[i] == 2'd0) px[i] <= bus_d[i];
        if (bus_addr[i] == 2'd1) py[i] <= bus_d[i];
      end
      if (bus_e[i] && bus_r[i] && bus_addr[i] == 2'd2)
        bus_out[i] <= stub_en ? stub_val
                    : (py[i] == 16'd0 ? 32'h0000_FFFF : {16'd0, px[i] / py[i]});
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bus_w[i] && bus_r[i]) overlap++;
      if (bus_e[i]) ecnt[i]++;
      if (done[i]) dcnt[i]++;
    end
    if (bus_e[0]) log_q.push_back({bus_r[0], bus_addr[0], bus_d[0]});
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic do_txn(input int s, input logic [15:0] x, input logic [15:0] y,
                        input logic stb, input logic [15:0] er, input logic edz,
                        input logic eerr, input int elat);
    int          e0, l0, lat;
    logic [15:0] prev;
    prev = last_res[s];
    @(negedge clk);
    stub_en  = stb;
    xin[s]   = x;
    yin[s]   = y;
    start[s] = 1'b1;
    e0 = ecnt[s];
    l0 = log_q.size();
    @(posedge clk); #1;
    start[s] = 1'b0;
    xin[s]   = 16'($urandom);
    yin[s]   = 16'($urandom);
    chk("busy_after_accept", busy[s], !edz);
    chk("result_before_done", result[s], edz ? er : prev);
    if (!edz) begin
      chk("dz_cleared", dz[s], 0);
      chk("err_cleared", err[s], 0);
    end
    lat = 0;
    while (!done[s] && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", lat, elat);
    chk("result", result[s], er);
    chk("dz", dz[s], edz);
    chk("err", err[s], eerr);
    chk("busy_at_done", busy[s], 0);
    @(posedge clk); #1;
    chk("done_one_cycle", done[s], 0);
    chk("dz_err_hold", {dz[s], err[s]}, {edz, eerr});
    chk("result_hold", result[s], er);
    chk("bus_e_cycles", ecnt[s] - e0, edz ? 0 : 3);
    if (s == 0 && !edz) begin
      chk("bus_log_len", log_q.size() - l0, 3);
      if (log_q.size() - l0 == 3) begin
        chk("bus_wr_x", log_q[l0], {1'b0, 2'd0, x});
        chk("bus_wr_y", log_q[l0+1], {1'b0, 2'd1, y});
        chk("bus_rd_q", log_q[l0+2][18:16], {1'b1, 2'd2});
      end
    end
    last_res[s] = er;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    int          n, nd, d0;
    logic        pb;
    logic [15:0] rx, ry;
    int          acc_q [$];

    rst      = 1'b1;
    start    = '{1'b0, 1'b0};
    xin      = '{16'd0, 16'd0};
    yin      = '{16'd0, 16'd0};
    stub_en  = 1'b0;
    stub_val = 32'h0001_0004;
    last_res = '{16'd0, 16'd0};
    ecnt     = '{0, 0};
    dcnt     = '{0, 0};
    #1;
    chk("reset_u0", {result[0], bus_d[0], bus_addr[0], done[0], busy[0], dz[0],
                     err[0], bus_w[0], bus_r[0], bus_e[0]}, 64'd0);
    chk("reset_u1", {result[1], bus_d[1], bus_addr[1], done[1], busy[1], dz[1],
                     err[1], bus_w[1], bus_r[1], bus_e[1]}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(posedge clk);

    vt[0] = '{16'd100,   16'd7,     1'b0, 16'd14,    1'b0, 1'b0, 5};
    vt[1] = '{16'd5,     16'd0,     1'b0, 16'hFFFF,  1'b1, 1'b0, 0};
    vt[2] = '{16'd9,     16'd3,     1'b0, 16'd3,     1'b0, 1'b0, 5};
    vt[3] = '{16'd65535, 16'd1,     1'b0, 16'd65535, 1'b0, 1'b0, 5};
    vt[4] = '{16'd100,   16'd7,     1'b1, 16'd4,     1'b0, 1'b1, 5};
    vt[5] = '{16'd0,     16'd5,     1'b0, 16'd0,     1'b0, 1'b0, 5};
    vt[6] = '{16'd65535, 16'd65535, 1'b0, 16'd1,     1'b0, 1'b0, 5};
    vt[7] = '{16'd1,     16'd2,     1'b0, 16'd0,     1'b0, 1'b0, 5};
    for (int i = 0; i < 8; i++)
      do_txn(0, vt[i].x, vt[i].y, vt[i].stub, vt[i].res, vt[i].dz, vt[i].err, vt[i].lat);

    for (int i = 0; i < 25; i++) begin
      rx = 16'($urandom);
      n  = int'($urandom_range(0, 5));
      ry = (n == 0) ? 16'd0 : (n < 3) ? 16'($urandom_range(1, 20)) : 16'($urandom);
      if (ry == 16'd0) do_txn(0, rx, ry, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0);
      else             do_txn(0, rx, ry, 1'b0, rx / ry, 1'b0, 1'b0, 5);
    end

    // START held high: accepts only at the first IDLE edge after each DONE.
    @(negedge clk);
    xin[0] = 16'd65535; yin[0] = 16'd1; start[0] = 1'b1;
    nd = 0;
    pb = busy[0];
    for (int c = 0; c < 24; c++) begin
      @(posedge clk); #1;
      if (busy[0] && !pb) acc_q.push_back(c);
      if (done[0]) begin
        nd++;
        chk("held_result", result[0], 16'hFFFF);
      end
      pb = busy[0];
      if (c == 16) start[0] = 1'b0;
    end
    chk("held_done_count", nd, 3);
    chk("held_accept_count", acc_q.size(), 3);
    if (acc_q.size() == 3) begin
      chk("held_accept_0", acc_q[0], 0);
      chk("held_accept_1", acc_q[1], 6);
      chk("held_accept_2", acc_q[2], 12);
    end
    last_res[0] = 16'hFFFF;

    // Reset during RD_Q, with START held across reset release.
    @(negedge clk);
    xin[0] = 16'd200; yin[0] = 16'd3; start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    n = 0;
    while (!bus_r[0] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reached_rd_q", bus_r[0], 1);
    #2 rst = 1'b1;
    #1;
    chk("abort_strobes", {bus_w[0], bus_r[0], bus_e[0], bus_addr[0]}, 0);
    chk("abort_outputs", {result[0], bus_d[0], done[0], busy[0], dz[0], err[0]}, 0);
    d0 = dcnt[0];
    xin[0] = 16'd9; yin[0] = 16'd3; start[0] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("start_at_release_ignored", busy[0], 0);
    chk("no_done_after_abort", dcnt[0] - d0, 0);
    last_res[0] = 16'd0;
    do_txn(0, 16'd9, 16'd3, 1'b0, 16'd3, 1'b0, 1'b0, 5);

    do_txn(1, 16'd1000, 16'd10, 1'b0, 16'd100, 1'b0, 1'b0, 8);
    do_txn(1, 16'd5, 16'd0, 1'b0, 16'hFFFF, 1'b1, 1'b0, 0);
    do_txn(1, 16'd50000, 16'd7, 1'b0, 16'd7142, 1'b0, 1'b0, 8);

    chk("no_w_r_overlap", overlap, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
